// File: rtl/pipe_cla_pkg.sv
// Shared constants and stage record fields for the pipelined CLA add/sub.
// Imported by the pipeline top and its lookahead slice.
package pipe_cla_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_STAGES = 4;

    // Control fields of one pipeline slot. The width-dependent fields
    // (partial sum and operands not yet consumed) are appended by the top.
    typedef struct packed {
        logic valid;
        logic carry;
        logic sub;
    } stage_ctl_t;

endpackage

// File: rtl/cla_slice.sv
// Combinational N-bit carry-lookahead chunk.
// Every carry is formed from group generate/propagate terms and ci.
module cla_slice
    import pipe_cla_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co,
    output logic         c_msb_in
);

    logic [N-1:0] g;
    logic [N-1:0] p;
    logic [N:0]   c;

    assign g = x & y;
    assign p = x ^ y;

    // Group generate/propagate prefix over bits [i:0] gives carry i+1.
    always_comb begin : lookahead
        logic gg;
        logic pp;
        c    = '0;
        gg   = 1'b0;
        pp   = 1'b1;
        c[0] = ci;
        for (int i = 0; i < N; i++) begin
            gg       = g[i] | (p[i] & gg);
            pp       = pp & p[i];
            c[i + 1] = gg | (pp & ci);
        end
    end

    assign s        = p ^ c[N-1:0];
    assign co       = c[N];
    assign c_msb_in = c[N-1];

endmodule

// File: rtl/pipe_cla_addsub.sv
// Skewed pipelined carry-lookahead adder/subtractor.
// Stage k resolves chunk k; one global enable stalls the whole pipe.
module pipe_cla_addsub
    import pipe_cla_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int STAGES = DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int SDIV  = (STAGES < 1) ? 1 : STAGES;
    localparam int CHUNK = WIDTH / SDIV;

    if ((STAGES < 1) || (WIDTH % SDIV != 0)) begin : g_bad_cfg
        $error("pipe_cla_addsub: WIDTH must be a multiple of STAGES >= 1");
    end

    typedef struct packed {
        stage_ctl_t       ctl;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
    } stage_t;

    stage_t           head;
    stage_t           src  [STAGES];
    stage_t           nxt  [STAGES];
    stage_t           r    [STAGES];
    logic [CHUNK-1:0] s_k  [STAGES];
    logic             co_k [STAGES];
    logic             cm_k [STAGES];
    logic             en;
    logic             ovf_q;
    logic             zero_q;

    // Fill chunk k of the partial sum and pass the chunk carry on.
    function automatic stage_t advance(input stage_t p,
                                       input logic [CHUNK-1:0] s,
                                       input logic co,
                                       input int k);
        stage_t n;
        n = p;
        n.psum[k*CHUNK +: CHUNK] = s;
        n.ctl.carry = co;
        return n;
    endfunction

    assign en       = !r[STAGES-1].ctl.valid | out_ready;
    assign in_ready = en;

    // Subtraction becomes a + ~b + ~cin, fixed once at acceptance.
    always_comb begin
        head           = '0;
        head.ctl.valid = in_valid;
        head.ctl.sub   = sub;
        head.ctl.carry = sub ? ~cin : cin;
        head.a_rem     = a;
        head.b_rem     = sub ? ~b : b;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign src[k] = head;
        end else begin : g_rest
            assign src[k] = r[k-1];
        end

        cla_slice #(.N(CHUNK)) u_slice (
            .x        (src[k].a_rem[k*CHUNK +: CHUNK]),
            .y        (src[k].b_rem[k*CHUNK +: CHUNK]),
            .ci       (src[k].ctl.carry),
            .s        (s_k[k]),
            .co       (co_k[k]),
            .c_msb_in (cm_k[k])
        );

        assign nxt[k] = advance(src[k], s_k[k], co_k[k], k);
    end

    // Advance every slot together; flags are formed with the last chunk.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r[k] <= '0;
            end
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < STAGES; k++) begin
                r[k] <= nxt[k];
            end
            ovf_q  <= co_k[STAGES-1] ^ cm_k[STAGES-1];
            zero_q <= (nxt[STAGES-1].psum == '0);
        end
    end

    assign out_valid = r[STAGES-1].ctl.valid;
    assign sum       = r[STAGES-1].psum;
    assign cout      = r[STAGES-1].ctl.carry;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
